demux2_buf: RTL and testbench

//  Receive end of the 2:1 select path: demultiplexes one tagged WIDTH-bit stream
//  (data + sel) back into two independent output channels, X (sel=0) and Y (sel=1).

---
 rtl/demux2_buf.sv | 105 ++++++++++
 tb/tb_demux2_buf.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/demux2_buf.sv
// Receive side of the 2:1 select path: routes a tagged input stream into two
// independent first-word-fall-through FIFOs, channel X (sel=0) and channel Y (sel=1).
module demux2_buf #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         x_data,
  output logic                     x_valid,
  input  logic                     x_ready,
  output logic [WIDTH-1:0]         y_data,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [$clog2(DEPTH):0]   x_count,
  output logic [$clog2(DEPTH):0]   y_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [WIDTH-1:0] r_x_mem [DEPTH];
  logic [WIDTH-1:0] r_y_mem [DEPTH];
  logic [AW-1:0]    r_x_wr, r_x_rd, r_y_wr, r_y_rd;
  logic [CW-1:0]    r_x_cnt, r_y_cnt;
  logic             r_x_valid, r_y_valid;

  logic             w_x_full, w_y_full;
  logic             w_x_push, w_y_push, w_x_pop, w_y_pop;
  logic [CW-1:0]    w_x_cnt_d, w_y_cnt_d;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
  always_comb begin
    w_x_full = (r_x_cnt == FullCnt);
    w_y_full = (r_y_cnt == FullCnt);
    in_ready = in_sel ? !w_y_full : !w_x_full;
    w_x_push = in_valid && !in_sel && !w_x_full;
    w_y_push = in_valid && in_sel && !w_y_full;
    w_x_pop  = r_x_valid && x_ready;
    w_y_pop  = r_y_valid && y_ready;

    w_x_cnt_d = r_x_cnt;
    if (w_x_push && !w_x_pop) begin
      w_x_cnt_d = r_x_cnt + CW'(1);
    end else if (!w_x_push && w_x_pop) begin
      w_x_cnt_d = r_x_cnt - CW'(1);
    end

    w_y_cnt_d = r_y_cnt;
    if (w_y_push && !w_y_pop) begin
      w_y_cnt_d = r_y_cnt + CW'(1);
    end else if (!w_y_push && w_y_pop) begin
      w_y_cnt_d = r_y_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_x_mem[i] <= '0;
        r_y_mem[i] <= '0;
      end
      r_x_wr    <= '0;
      r_x_rd    <= '0;
      r_y_wr    <= '0;
      r_y_rd    <= '0;
      r_x_cnt   <= '0;
      r_y_cnt   <= '0;
      r_x_valid <= 1'b0;
      r_y_valid <= 1'b0;
    end else begin
      if (w_x_push) begin
        r_x_mem[r_x_wr] <= in_data;
        r_x_wr          <= r_x_wr + AW'(1);
      end
      if (w_x_pop) begin
        r_x_rd <= r_x_rd + AW'(1);
      end
      if (w_y_push) begin
        r_y_mem[r_y_wr] <= in_data;
        r_y_wr          <= r_y_wr + AW'(1);
      end
      if (w_y_pop) begin
        r_y_rd <= r_y_rd + AW'(1);
      end
      r_x_cnt   <= w_x_cnt_d;
      r_y_cnt   <= w_y_cnt_d;
      r_x_valid <= (w_x_cnt_d != '0);
      r_y_valid <= (w_y_cnt_d != '0);
    end
  end

  assign x_data  = r_x_mem[r_x_rd];
  assign y_data  = r_y_mem[r_y_rd];
  assign x_valid = r_x_valid;
  assign y_valid = r_y_valid;
  assign x_count = r_x_cnt;
  assign y_count = r_y_cnt;

endmodule

// File: tb/tb_demux2_buf.sv
// Scoreboard bench for demux2_buf: per-channel expected-word queues filled on accept,
// drained and compared by an independent monitor.
module tb_demux2_buf;
  localparam int WIDTH = 5;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel, in_valid, in_ready;
  logic [WIDTH-1:0] x_data, y_data;
  logic             x_valid, x_ready, y_valid, y_ready;
  logic [$clog2(DEPTH):0] x_count, y_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] qx[$];
  logic [WIDTH-1:0] qy[$];

  demux2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .x_count(x_count), .y_count(y_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: inputs change 2 units after the edge, acceptance is
  // decided 1 unit later and the accepted word is queued as expected output.
  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d,
                       input logic xr, input logic yr, output logic acc);
    logic exp_rdy;
    @(posedge clk);
    #2;
    in_valid = v; in_sel = s; in_data = d; x_ready = xr; y_ready = yr;
    #1;
    exp_rdy = s ? (qy.size() < DEPTH) : (qx.size() < DEPTH);
    check("in_ready", int'(in_ready), int'(exp_rdy));
    acc = v && in_ready;
    if (acc) begin
      if (s) qy.push_back(d);
      else   qx.push_back(d);
    end
  endtask

  task automatic drain();
    logic acc;
    repeat (2 * DEPTH + 2) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
  endtask

  // Monitor: state check just after each edge, pop of consumed heads before the next.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("x_valid", int'(x_valid), int'(qx.size() != 0));
        check("y_valid", int'(y_valid), int'(qy.size() != 0));
        check("x_count", int'(x_count), qx.size());
        check("y_count", int'(y_count), qy.size());
        if (qx.size() != 0) check("x_data", int'(x_data), int'(qx[0]));
        if (qy.size() != 0) check("y_data", int'(y_data), int'(qy[0]));
      end
      #3;
      if (!rst) begin
        if (x_valid && x_ready) begin
          if (qx.size() == 0) check("x_underflow", 1, 0);
          else void'(qx.pop_front());
        end
        if (y_valid && y_ready) begin
          if (qy.size() == 0) check("y_underflow", 1, 0);
          else void'(qy.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int i, guard;
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0; x_ready = 1'b0; y_ready = 1'b0;
    #1;
    check("rst_x_valid", int'(x_valid), 0);
    check("rst_y_valid", int'(y_valid), 0);
    check("rst_x_count", int'(x_count), 0);
    check("rst_y_count", int'(y_count), 0);
    check("rst_x_data", int'(x_data), 0);
    check("rst_y_data", int'(y_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Routing
    drive(1'b1, 1'b0, 5'h0A, 1'b1, 1'b1, acc);
    check("route_x_acc", int'(acc), 1);
    drive(1'b1, 1'b1, 5'h15, 1'b1, 1'b1, acc);
    check("route_x_valid", int'(x_valid), 1);
    check("route_x_data", int'(x_data), 'h0A);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
    check("route_y_valid", int'(y_valid), 1);
    check("route_y_data", int'(y_data), 'h15);
    drain();

    // Full and backpressure
    drive(1'b1, 1'b0, 5'h01, 1'b0, 1'b1, acc);
    drive(1'b1, 1'b0, 5'h02, 1'b0, 1'b1, acc);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
    check("full_x_count", int'(x_count), 2);
    check("full_rdy_sel0", int'(in_ready), 0);
    in_sel = 1'b1;
    #1;
    check("full_rdy_sel1", int'(in_ready), 1);
    drive(1'b1, 1'b0, 5'h03, 1'b1, 1'b1, acc);
    check("full_pop_no_accept", int'(acc), 0);
    drive(1'b1, 1'b1, 5'h1F, 1'b0, 1'b1, acc);
    check("full_y_accept", int'(acc), 1);
    drain();

    // Simultaneous push and pop on X
    drive(1'b1, 1'b0, 5'h07, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 5'h08, 1'b1, 1'b0, acc);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, acc);
    check("simul_x_count", int'(x_count), 1);
    check("simul_x_head", int'(x_data), 'h08);
    drain();

    // Ordered stream with gaps
    i = 0;
    guard = 0;
    while (i < 32 && guard < 2000) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 5'(i), 1'b1, 1'($urandom_range(0, 1)), acc);
      if (acc) i++;
      guard++;
    end
    check("stream_all_sent", i, 32);
    drain();

    // Random traffic
    repeat (10000) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 6), acc);
    end
    drain();
    check("end_qx_empty", qx.size(), 0);
    check("end_qy_empty", qy.size(), 0);

    // Asynchronous reset with both channels loaded
    drive(1'b1, 1'b0, 5'h11, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b1, 5'h12, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 5'h13, 1'b0, 1'b0, acc);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    check("pre_rst_x_count", int'(x_count), 2);
    check("pre_rst_y_count", int'(y_count), 1);
    rst = 1'b1;
    #1;
    check("arst_x_valid", int'(x_valid), 0);
    check("arst_y_valid", int'(y_valid), 0);
    check("arst_x_count", int'(x_count), 0);
    check("arst_y_count", int'(y_count), 0);
    check("arst_x_data", int'(x_data), 0);
    check("arst_y_data", int'(y_data), 0);
    qx.delete();
    qy.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'h1C, 1'b1, 1'b1, acc);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, acc);
    check("post_rst_y_data", int'(y_data), 'h1C);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
